wb_ram_arb: RTL and testbench
=============================

WB_RAM_ARB -- requirements
Module: wb_ram_arb

Interface
REQ-001 SHALL have parameter AW, default 10, meaning the word-address width shared by masters and slave.
REQ-002 SHALL have parameter HOLD_MAX, default 8, meaning the acks granted to one master before a forced release when the other master is waiting; range 1..255.
REQ-003 SHALL have port clk_i  in  1  the single clock.
REQ-004 SHALL have port rst_in  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  Wishbone master 0 (instruction fetch) control.
REQ-006 SHALL have ports m0_sel_i  in  4, m0_dat_i  in  32, m0_adr_i  in  AW  master 0 byte select, write data and word address.
REQ-007 SHALL have ports m0_ack_o  out  1 and m0_dat_o  out  32  master 0 acknowledge and read data.
REQ-008 SHALL have the same set, prefixed m1_, for master 1 (data port).
REQ-009 SHALL have ports s_cyc_o, s_stb_o, s_we_o  out  1, s_sel_o  out  4, s_dat_o  out  32, s_adr_o  out  AW  slave request toward the RAM.
REQ-010 SHALL have ports s_ack_i  in  1 and s_dat_i  in  32  slave acknowledge and read data; the slave acks one cycle after each cycle in which it sees cyc&stb.

Function
REQ-011 SHALL implement the registered FSM states IDLE, GNT0 and GNT1; a request from master x is mx_cyc_i&mx_stb_i.
REQ-012 In IDLE, a single request SHALL move the FSM to GNTx on the next edge; simultaneous requests SHALL be resolved by the priority rule in REQ-025/026.
REQ-013 In GNTx, s_* outputs SHALL be combinational copies of the mx_* inputs; in IDLE, s_cyc_o and s_stb_o SHALL be 0 and all other s_* outputs SHALL be 0.
REQ-014 GNTx SHALL return to IDLE on the edge after mx_cyc_i is sampled low.
REQ-015 GNTx SHALL count acks routed to master x in an 8-bit counter that clears on entry to GNTx.
REQ-016 When the counter reaches HOLD_MAX on an ack while the other master requests, the FSM SHALL go to IDLE on that edge even if mx_cyc_i stays high; master x is then stalled with no ack, which is legal Wishbone.
REQ-017 A registered owner flag SHALL record which master drove s_stb_o in the previous cycle, and s_ack_i SHALL be routed only to that master.
REQ-018 mx_ack_o SHALL be s_ack_i & (owner==x) & owner_valid; a non-owner ack SHALL be 0.
REQ-019 mx_dat_o SHALL be s_dat_i for both masters, valid only while mx_ack_o is high.
REQ-020 An ack that arrives in the first IDLE cycle after a release SHALL still reach the previous owner.
REQ-021 A master SHALL never receive an ack in a cycle following one in which it was not granted with stb high.
REQ-022 The FSM SHALL never pass directly from GNT0 to GNT1 or the reverse; IDLE lasts at least one cycle, so the turnaround is one cycle.

Reset
REQ-023 While rst_in is low, the block SHALL asynchronously force the FSM to IDLE, clear owner_valid and the hold counter, and set the round-robin pointer to master 0.
REQ-024 During reset, all outputs SHALL be 0; an assertion in the middle of a transfer SHALL drop s_cyc_o and the mx_ack_o outputs at once.

Configuration
REQ-025 With WB_RAM_ARB_RR_EN defined, simultaneous requests in IDLE SHALL be granted round-robin: a 1-bit pointer names the preferred master and toggles to the other master on every grant.
REQ-026 Without WB_RAM_ARB_RR_EN, master 0 SHALL always win simultaneous requests, and the REQ-016 forced release SHALL apply only to master 0.

Verification
REQ-027 The bench SHALL cover: after reset, m1 requests a read of adr 0x005 -> GNT1 next cycle, m1_ack_o exactly 1 cycle after s_stb_o, m1_dat_o equals the RAM word, m0_ack_o stays 0.
REQ-028 The bench SHALL cover: both masters request in the same IDLE cycle with RR_EN -> first m0 is granted, then m1 is granted after m0 drops cyc; without RR_EN, m0 is granted both times.
REQ-029 The bench SHALL cover: m0 streams 20 reads with cyc held, m1 waiting, HOLD_MAX=8 -> m0 gets exactly 8 acks, 1 IDLE cycle, then m1 is granted.
REQ-030 The bench SHALL cover: m1 writes 0xDEADBEEF with sel=4'b0011 to adr 0x200, then m0 reads adr 0x200 -> the read returns the low 16 bits updated and the upper bits unchanged.
REQ-031 The bench SHALL cover: rst_in pulled low mid-burst in GNT0 -> s_cyc_o is 0 in the same cycle, no ack reaches m0, and the FSM is in IDLE after rst_in is released.
REQ-032 The bench SHALL cover: a release happens with an ack pending -> that ack goes to the old owner in IDLE, and the new master's first ack comes 2 cycles later.

Source files
------------

// File: rtl/wb_ram_arb.sv
// -----------------------------------------------------------------------------
// wb_ram_arb
// Two-master Wishbone arbiter in front of a single-ported RAM slave.
// Master 0 is the instruction-fetch port and master 1 the data port. A
// three-state FSM (IDLE, GNT0, GNT1) grants one master at a time. While a
// master is granted, the slave request is a combinational copy of that master's
// bus. Every hand-over passes through at least one IDLE cycle.
//
// Fairness: a granted master that has collected HOLD_MAX acks while the other
// master is waiting is forced back to IDLE. Its bus is then stalled (no ack)
// until it is granted again.
//
// Acks come back one cycle after the slave sees cyc&stb. They are therefore
// steered by a registered owner flag that records who drove stb in the
// previous cycle, and not by the current grant. As a result, an ack still
// reaches the previous owner in the IDLE cycle that follows a release.
//
// Configuration macro: WB_RAM_ARB_RR_EN
//   defined   - simultaneous requests in IDLE are granted round-robin, and the
//               forced release applies to both masters.
//   undefined - master 0 wins simultaneous requests and only master 0 is
//               subject to the forced release. The one exception is the IDLE
//               cycle that directly follows a forced release of master 0:
//               in that cycle the waiting master 1 is granted, so the release
//               actually hands the RAM over.
//
// Parameters
//   AW        word-address width shared by masters and slave
//   HOLD_MAX  acks granted to one master before a forced release (1..255)
//
// Ports
//   clk_i, rst_in                      clock, asynchronous active-low reset
//   m0_cyc_i/stb_i/we_i/sel_i/dat_i/adr_i   master 0 request
//   m0_ack_o/dat_o                     master 0 acknowledge and read data
//   m1_*                               the same set for master 1
//   s_cyc_o/stb_o/we_o/sel_o/dat_o/adr_o    request toward the RAM
//   s_ack_i/dat_i                      RAM acknowledge and read data
// -----------------------------------------------------------------------------
module wb_ram_arb #(
  parameter int AW       = 10,
  parameter int HOLD_MAX = 8
) (
  input  logic          clk_i,
  input  logic          rst_in,
  // master 0 (instruction fetch)
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [3:0]    m0_sel_i,
  input  logic [31:0]   m0_dat_i,
  input  logic [AW-1:0] m0_adr_i,
  output logic          m0_ack_o,
  output logic [31:0]   m0_dat_o,
  // master 1 (data port)
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [3:0]    m1_sel_i,
  input  logic [31:0]   m1_dat_i,
  input  logic [AW-1:0] m1_adr_i,
  output logic          m1_ack_o,
  output logic [31:0]   m1_dat_o,
  // slave (RAM)
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [3:0]    s_sel_o,
  output logic [31:0]   s_dat_o,
  output logic [AW-1:0] s_adr_o,
  input  logic          s_ack_i,
  input  logic [31:0]   s_dat_i
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  // A release fires on the ack that brings the count to HOLD_MAX, that is,
  // when the count before that ack is HOLD_MAX-1.
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_t      state_reg, state_next;
  logic        owner_reg, owner_next;
  logic        owner_valid_reg, owner_valid_next;
  logic [7:0]  hold_cnt_reg, hold_cnt_next;
  logic        req0, req1;
  logic        ack0, ack1;
  logic        pick1;
`ifdef WB_RAM_ARB_RR_EN
  logic        rr_ptr_reg, rr_ptr_next;
`else
  logic        forced_reg, forced_next;
`endif

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  // Acks follow whoever drove stb last cycle, independent of the current grant.
  assign ack0 = s_ack_i & owner_valid_reg & ~owner_reg;
  assign ack1 = s_ack_i & owner_valid_reg &  owner_reg;

  assign m0_ack_o = ack0;
  assign m1_ack_o = ack1;
  // Read data is shared. It is held at zero whenever no ack can be routed,
  // which keeps it quiet during reset.
  assign m0_dat_o = owner_valid_reg ? s_dat_i : 32'h0;
  assign m1_dat_o = owner_valid_reg ? s_dat_i : 32'h0;

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_reg       <= IDLE;
      owner_reg       <= 1'b0;
      owner_valid_reg <= 1'b0;
      hold_cnt_reg    <= 8'd0;
`ifdef WB_RAM_ARB_RR_EN
      rr_ptr_reg      <= 1'b0;
`else
      forced_reg      <= 1'b0;
`endif
    end else begin
      state_reg       <= state_next;
      owner_reg       <= owner_next;
      owner_valid_reg <= owner_valid_next;
      hold_cnt_reg    <= hold_cnt_next;
`ifdef WB_RAM_ARB_RR_EN
      rr_ptr_reg      <= rr_ptr_next;
`else
      forced_reg      <= forced_next;
`endif
    end
  end

  always_comb begin
    state_next       = state_reg;
    owner_next       = owner_reg;
    owner_valid_next = 1'b0;
    hold_cnt_next    = hold_cnt_reg;
    pick1            = 1'b0;
`ifdef WB_RAM_ARB_RR_EN
    rr_ptr_next      = rr_ptr_reg;
`else
    forced_next      = 1'b0;
`endif
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = 4'h0;
    s_dat_o = 32'h0;
    s_adr_o = '0;

    unique case (state_reg)
      IDLE: begin
        // The counter restarts for whichever master is granted next.
        hold_cnt_next = 8'd0;
        if (req0 && req1) begin
`ifdef WB_RAM_ARB_RR_EN
          pick1 = rr_ptr_reg;
`else
          pick1 = forced_reg;
`endif
        end else begin
          pick1 = req1;
        end
        if (req0 || req1) begin
          state_next = pick1 ? GNT1 : GNT0;
`ifdef WB_RAM_ARB_RR_EN
          rr_ptr_next = ~pick1;
`endif
        end
      end

      GNT0: begin
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i;
        s_we_o  = m0_we_i;
        s_sel_o = m0_sel_i;
        s_dat_o = m0_dat_i;
        s_adr_o = m0_adr_i;
        owner_next       = 1'b0;
        owner_valid_next = m0_cyc_i & m0_stb_i;
        if (ack0 && hold_cnt_reg != 8'hFF) begin
          hold_cnt_next = hold_cnt_reg + 8'd1;
        end
        if (!m0_cyc_i) begin
          state_next = IDLE;
        end else if (ack0 && req1 && hold_cnt_reg >= HOLD_LAST) begin
          state_next = IDLE;
`ifndef WB_RAM_ARB_RR_EN
          forced_next = 1'b1;
`endif
        end
      end

      GNT1: begin
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i;
        s_we_o  = m1_we_i;
        s_sel_o = m1_sel_i;
        s_dat_o = m1_dat_i;
        s_adr_o = m1_adr_i;
        owner_next       = 1'b1;
        owner_valid_next = m1_cyc_i & m1_stb_i;
        if (ack1 && hold_cnt_reg != 8'hFF) begin
          hold_cnt_next = hold_cnt_reg + 8'd1;
        end
        if (!m1_cyc_i) begin
          state_next = IDLE;
        end
`ifdef WB_RAM_ARB_RR_EN
        else if (ack1 && req0 && hold_cnt_reg >= HOLD_LAST) begin
          state_next = IDLE;
        end
`endif
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_ram_arb.sv
// -----------------------------------------------------------------------------
// tb_wb_ram_arb
// Directed bench for wb_ram_arb. The bench contains a 1024-word RAM model that
// acks one cycle after each cyc&stb cycle. Inputs change on the falling edge,
// and outputs are sampled 1 ns later, which is well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_wb_ram_arb;

  localparam int AW = 10;

  logic          clk_i = 1'b0;
  logic          rst_in = 1'b0;
  logic          m0_cyc_i, m0_stb_i, m0_we_i;
  logic [3:0]    m0_sel_i;
  logic [31:0]   m0_dat_i;
  logic [AW-1:0] m0_adr_i;
  logic          m0_ack_o;
  logic [31:0]   m0_dat_o;
  logic          m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]    m1_sel_i;
  logic [31:0]   m1_dat_i;
  logic [AW-1:0] m1_adr_i;
  logic          m1_ack_o;
  logic [31:0]   m1_dat_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]    s_sel_o;
  logic [31:0]   s_dat_o;
  logic [AW-1:0] s_adr_o;
  logic          s_ack_i = 1'b0;
  logic [31:0]   s_dat_i = 32'h0;

  logic [31:0]   mem [0:1023];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  wb_ram_arb #(.AW(AW), .HOLD_MAX(8)) dut (
    .clk_i(clk_i), .rst_in(rst_in),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i), .m0_adr_i(m0_adr_i),
    .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i), .m1_adr_i(m1_adr_i),
    .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_adr_o(s_adr_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i)
  );

  function automatic logic [31:0] init_word(input int a);
    return 32'h5A00_0000 | (32'(a) << 12) | 32'(a);
  endfunction

  // RAM slave: the ack is registered, and writes honour the byte selects.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
  end

  always @(posedge clk_i) begin
    s_ack_i <= s_cyc_o & s_stb_o;
    if (s_cyc_o && s_stb_o) begin
      if (s_we_o) begin
        for (int b = 0; b < 4; b++)
          if (s_sel_o[b]) mem[s_adr_o][8*b +: 8] <= s_dat_o[8*b +: 8];
      end else begin
        s_dat_i <= mem[s_adr_o];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic set_m0(input logic cyc, input logic stb, input logic we,
                        input logic [3:0] sel, input logic [31:0] dat, input logic [AW-1:0] adr);
    m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we;
    m0_sel_i = sel; m0_dat_i = dat; m0_adr_i = adr;
  endtask

  task automatic set_m1(input logic cyc, input logic stb, input logic we,
                        input logic [3:0] sel, input logic [31:0] dat, input logic [AW-1:0] adr);
    m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we;
    m1_sel_i = sel; m1_dat_i = dat; m1_adr_i = adr;
  endtask

  task automatic step;
    @(negedge clk_i);
  endtask

  task automatic do_reset(input string tag);
    step;
    rst_in = 1'b0;
    set_m0(0, 0, 0, 4'h0, 32'h0, '0);
    set_m1(0, 0, 0, 4'h0, 32'h0, '0);
    #1;
    check({tag, "_rst_s_cyc"}, 32'(s_cyc_o), 32'd0);
    check({tag, "_rst_acks"},  32'({m0_ack_o, m1_ack_o}), 32'd0);
    check({tag, "_rst_m0_dat"}, m0_dat_o, 32'h0);
    step;
    step;
    rst_in = 1'b1;
  endtask

  logic [AW-1:0] exp_adr;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    set_m0(0, 0, 0, 4'h0, 32'h0, '0);
    set_m1(0, 0, 0, 4'h0, 32'h0, '0);

    // ---- m1 single read of 0x005 after reset
    do_reset("a");
    step; set_m1(1, 1, 0, 4'hF, 32'h0, 10'h005); #1;
    check("a_idle_s_cyc", 32'(s_cyc_o), 32'd0);
    step; #1;
    check("a_gnt1_s_cyc", 32'(s_cyc_o), 32'd1);
    check("a_gnt1_s_adr", 32'(s_adr_o), 32'h005);
    check("a_no_early_ack", 32'(m1_ack_o), 32'd0);
    step; set_m1(1, 0, 0, 4'hF, 32'h0, 10'h005); #1;
    check("a_m1_ack", 32'(m1_ack_o), 32'd1);
    check("a_m1_dat", m1_dat_o, init_word(5));
    check("a_m0_ack", 32'(m0_ack_o), 32'd0);
    step; set_m1(0, 0, 0, 4'h0, 32'h0, 10'h005); #1;
    check("a_m1_ack_once", 32'(m1_ack_o), 32'd0);
    step; #1;
    check("a_back_idle", 32'(s_cyc_o), 32'd0);

    // ---- simultaneous requests, m0 re-requests in the turnaround cycle
    do_reset("b");
    step; set_m0(1, 1, 0, 4'hF, 32'h0, 10'h010); set_m1(1, 1, 0, 4'hF, 32'h0, 10'h020); #1;
    check("b_idle_s_cyc", 32'(s_cyc_o), 32'd0);
    step; #1;
    check("b_first_gnt_adr", 32'(s_adr_o), 32'h010);
    step; set_m0(1, 0, 0, 4'hF, 32'h0, 10'h010); #1;
    check("b_m0_ack", 32'(m0_ack_o), 32'd1);
    check("b_m0_dat", m0_dat_o, init_word(16));
    check("b_m1_no_ack", 32'(m1_ack_o), 32'd0);
    step; set_m0(0, 0, 0, 4'h0, 32'h0, 10'h010); #1;
    step; set_m0(1, 1, 0, 4'hF, 32'h0, 10'h011); #1;
    check("b_turnaround_idle", 32'(s_cyc_o), 32'd0);
`ifdef WB_RAM_ARB_RR_EN
    exp_adr = 10'h020;
`else
    exp_adr = 10'h011;
`endif
    step; #1;
    check("b_second_gnt_adr", 32'(s_adr_o), 32'(exp_adr));

    // ---- hold limit: classic m0 reads, m1 waiting
    do_reset("c");
    for (int n = 0; n < 26; n++) begin
      step;
      set_m0(1, (n == 0) || (n % 2 == 1), 0, 4'hF, 32'h0, 10'h061);
      set_m1(n >= 1, n >= 1, 0, 4'hF, 32'h0, 10'h070);
      #1;
      check($sformatf("c_s_cyc_%0d", n), 32'(s_cyc_o), 32'(n >= 1 && n != 17));
      check($sformatf("c_m0_ack_%0d", n), 32'(m0_ack_o), 32'(n >= 2 && n <= 16 && n % 2 == 0));
      check($sformatf("c_m1_ack_%0d", n), 32'(m1_ack_o), 32'(n >= 19));
      if (n == 18) check("c_m1_gnt_adr", 32'(s_adr_o), 32'h070);
    end

    // ---- partial write by m1, read back by m0
    do_reset("d");
    step; set_m1(1, 1, 1, 4'b0011, 32'hDEADBEEF, 10'h200); #1;
    step; #1;
    check("d_s_we", 32'(s_we_o), 32'd1);
    check("d_s_sel", 32'(s_sel_o), 32'h3);
    check("d_s_dat", s_dat_o, 32'hDEADBEEF);
    step; set_m1(1, 0, 1, 4'b0011, 32'hDEADBEEF, 10'h200); #1;
    check("d_wr_ack", 32'(m1_ack_o), 32'd1);
    step; set_m1(0, 0, 0, 4'h0, 32'h0, 10'h200); #1;
    step; set_m0(1, 1, 0, 4'hF, 32'h0, 10'h200); #1;
    step; #1;
    check("d_rd_adr", 32'(s_adr_o), 32'h200);
    step; set_m0(1, 0, 0, 4'hF, 32'h0, 10'h200); #1;
    check("d_rd_ack", 32'(m0_ack_o), 32'd1);
    check("d_rd_dat", m0_dat_o, {init_word(32'h200) >> 16, 16'hBEEF});
    step; set_m0(0, 0, 0, 4'h0, 32'h0, 10'h200); #1;

    // ---- reset asserted mid-burst in GNT0
    do_reset("e");
    step; set_m0(1, 1, 0, 4'hF, 32'h0, 10'h040); #1;
    step; #1;
    check("e_gnt0_s_cyc", 32'(s_cyc_o), 32'd1);
    step; #1;
    check("e_burst_ack", 32'(m0_ack_o), 32'd1);
    step; #1;
    check("e_burst_ack2", 32'(m0_ack_o), 32'd1);
    #2 rst_in = 1'b0; #1;
    check("e_rst_s_cyc_now", 32'(s_cyc_o), 32'd0);
    check("e_rst_m0_ack_now", 32'(m0_ack_o), 32'd0);
    check("e_rst_m0_dat_now", m0_dat_o, 32'h0);
    step; #1;
    check("e_rst_hold_s_cyc", 32'(s_cyc_o), 32'd0);
    check("e_rst_hold_ack", 32'(m0_ack_o), 32'd0);
    step; rst_in = 1'b1; #1;
    check("e_after_rst_idle", 32'(s_cyc_o), 32'd0);
    check("e_after_rst_ack", 32'(m0_ack_o), 32'd0);
    step; #1;
    check("e_regrant", 32'(s_cyc_o), 32'd1);

    // ---- forced release with an ack still in flight
    do_reset("f");
    for (int n = 0; n <= 12; n++) begin
      step;
      set_m0(1, 1, 0, 4'hF, 32'h0, 10'h050);
      set_m1(n >= 1, n >= 1, 0, 4'hF, 32'h0, 10'h066);
      #1;
      check($sformatf("f_s_cyc_%0d", n), 32'(s_cyc_o), 32'(n >= 1 && n != 10));
      check($sformatf("f_m0_ack_%0d", n), 32'(m0_ack_o), 32'(n >= 2 && n <= 10));
      check($sformatf("f_m1_ack_%0d", n), 32'(m1_ack_o), 32'(n == 12));
      if (n == 10) check("f_idle_m0_dat", m0_dat_o, init_word(32'h050));
      if (n == 11) check("f_m1_gnt_adr", 32'(s_adr_o), 32'h066);
      if (n == 12) check("f_m1_dat", m1_dat_o, init_word(32'h066));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
